// File: rtl/dffe_pipe_pkg.sv
// rtl/dffe_pipe_pkg.sv - shared types and width helpers for the elastic pipeline register
//
// Purpose:
//   Holds the default data width, the stall-mode enumeration and the helper
//   that sizes the occupancy counter. Imported by the interface, the stage
//   register and the top.

package dffe_pipe_pkg;

  // Default width of one data stage when a user does not override it.
  localparam int data_width_default = 32;

  // How the stages react to a downstream stall.
  typedef enum logic {
    mode_lockstep = 1'b0,  // every stage freezes while held
    mode_collapse = 1'b1   // bubbles may be squeezed out while held
  } mode_e;

  // Width needed to count 0..n valid stages. Never narrower than one bit so
  // that a single-stage pipe still has a usable occupancy port.
  function automatic int occ_width(input int n);
    if (n < 1) return 1;
    return (($clog2(n + 1)) < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dffe_pipe_if.sv
// rtl/dffe_pipe_if.sv - handshake, stall, flush and status bundle for dffe_pipe
//
// Purpose:
//   Groups everything that crosses the pipeline boundary except clock and
//   reset. The producer/consumer side uses modport master, the pipeline uses
//   modport slave.
//
// Signals:
//   hold       downstream cannot accept the last stage this cycle
//   flush      per-stage squash of the value entering that stage
//   valid_in   data_in carries a valid item
//   data_in    input data
//   ready_in   input accepted on an edge where valid_in & ready_in
//   valid_out  valid bit of the last stage
//   data_out   data of the last stage (visible even when not valid)
//   occupancy  registered count of valid stages

interface dffe_pipe_if
  import dffe_pipe_pkg::*;
#(
  parameter int data_width = data_width_default,
  parameter int depth      = 1
);

  localparam int occ_w = occ_width(depth);

  logic                  hold;
  logic [depth-1:0]      flush;
  logic                  valid_in;
  logic [data_width-1:0] data_in;
  logic                  ready_in;
  logic                  valid_out;
  logic [data_width-1:0] data_out;
  logic [occ_w-1:0]      occupancy;

  modport master (
    output hold, flush, valid_in, data_in,
    input  ready_in, valid_out, data_out, occupancy
  );

  modport slave (
    input  hold, flush, valid_in, data_in,
    output ready_in, valid_out, data_out, occupancy
  );

endinterface

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid+data stage of the elastic pipeline
//
// Purpose:
//   A single pipeline slot. When load is high it takes the upstream valid bit
//   (squashed by flush) and, only if that upstream value is valid, the
//   upstream data. When load is low it keeps its contents, but flush can
//   still kill the valid bit.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   load       this stage advances at the coming edge
//   flush      invalidate whatever this stage holds after the coming edge
//   src_valid  valid bit of the upstream stage (or the pipe input)
//   src_data   data of the upstream stage (or the pipe input)
//   valid      registered valid bit
//   valid_nxt  valid bit this stage will hold after the coming edge
//   data       registered data

module pipe_stage
  import dffe_pipe_pkg::*;
#(
  parameter int                    data_width  = data_width_default,
  parameter logic [data_width-1:0] reset_value = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  flush,
  input  logic                  src_valid,
  input  logic [data_width-1:0] src_data,
  output logic                  valid,
  output logic                  valid_nxt,
  output logic [data_width-1:0] data
);

  // Exposed so the top can count next-state valid bits for occupancy
  // without duplicating this decision.
  always_comb begin
    valid_nxt = valid;
    if (load) begin
      valid_nxt = src_valid & ~flush;
    end else if (flush) begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= reset_value;
    end else begin
      valid <= valid_nxt;
      // Bubbles leave the data register untouched so it does not toggle.
      if (load && src_valid) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/dffe_pipe.sv
// rtl/dffe_pipe.sv - parametrised elastic pipeline register with stall, flush and bubble collapse
//
// Purpose:
//   depth stages of data_width-bit data, each with a valid bit. Stage 0 is
//   the input side, stage depth-1 drives the outputs. In lockstep mode every
//   stage freezes on hold; in collapse mode a stage may still advance while
//   held if some stage at or after it is empty.
//
// Parameters:
//   data_width   width of each data stage
//   depth        number of stages (>= 1)
//   collapse     0 = lockstep stall, 1 = squeeze bubbles while held
//   reset_value  value loaded into every data stage on reset
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  dffe_pipe_if.slave: hold, flush, valid_in, data_in in;
//        ready_in, valid_out, data_out, occupancy out

module dffe_pipe
  import dffe_pipe_pkg::*;
#(
  parameter int                    data_width  = data_width_default,
  parameter int                    depth       = 1,
  parameter int                    collapse    = 0,
  parameter logic [data_width-1:0] reset_value = '0
) (
  input logic         clk,
  input logic         rst,
  dffe_pipe_if.slave  bus
);

  localparam int    occ_w = occ_width(depth);
  localparam mode_e mode  = (collapse != 0) ? mode_collapse : mode_lockstep;

  logic [depth-1:0]      v;
  logic [depth-1:0]      v_nxt;
  logic [depth-1:0]      adv;
  logic [data_width-1:0] d [depth];
  logic [occ_w-1:0]      occ_q;
  logic [occ_w-1:0]      occ_nxt;

  // Advance chain. In collapse mode an empty stage can always take a new
  // value, and a full stage can move on only if its successor advances.
  generate
    if (mode == mode_collapse) begin : g_adv_collapse
      always_comb begin
        adv            = '0;
        adv[depth-1]   = ~bus.hold | ~v[depth-1];
        for (int i = depth - 2; i >= 0; i--) begin
          adv[i] = adv[i+1] | ~v[i];
        end
      end
    end else begin : g_adv_lockstep
      assign adv = {depth{~bus.hold}};
    end
  endgenerate

  generate
    for (genvar i = 0; i < depth; i++) begin : g_stage
      logic                  src_valid;
      logic [data_width-1:0] src_data;

      if (i == 0) begin : g_head
        assign src_valid = bus.valid_in;
        assign src_data  = bus.data_in;
      end else begin : g_body
        assign src_valid = v[i-1];
        assign src_data  = d[i-1];
      end

      pipe_stage #(
        .data_width  (data_width),
        .reset_value (reset_value)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (adv[i]),
        .flush     (bus.flush[i]),
        .src_valid (src_valid),
        .src_data  (src_data),
        .valid     (v[i]),
        .valid_nxt (v_nxt[i]),
        .data      (d[i])
      );
    end
  endgenerate

  // Occupancy is registered from the next-state valid bits so it always
  // matches the popcount of the valid registers after every edge.
  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < depth; i++) begin
      occ_nxt = occ_nxt + occ_w'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_nxt;
    end
  end

  // A flushed input is still reported as accepted; it is just dropped.
  assign bus.ready_in  = adv[0];
  assign bus.valid_out = v[depth-1];
  assign bus.data_out  = d[depth-1];
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_dffe_pipe.sv
// tb/tb_dffe_pipe.sv - self-checking bench for dffe_pipe in lockstep and collapse modes

module tb_dffe_pipe;

  localparam int         dw   = 4;
  localparam int         dep  = 3;
  localparam logic [3:0] rval = 4'hA;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dffe_pipe_if #(.data_width(dw), .depth(dep)) if0 ();
  dffe_pipe_if #(.data_width(dw), .depth(dep)) if1 ();

  dffe_pipe #(.data_width(dw), .depth(dep), .collapse(0), .reset_value(rval)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  dffe_pipe #(.data_width(dw), .depth(dep), .collapse(1), .reset_value(rval)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  typedef struct {
    logic       vi;
    logic [3:0] di;
    logic       hold;
    logic [2:0] flush;
    logic       e_ready;
    logic       e_vo;
    logic [3:0] e_do;
    logic [1:0] e_occ;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] sb[$];
  int         tests  = 0;
  int         failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vi, input logic [3:0] di, input logic hold,
                              input logic [2:0] flush, input logic e_ready, input logic e_vo,
                              input logic [3:0] e_do, input logic [1:0] e_occ);
    vec_t r;
    r.vi = vi; r.di = di; r.hold = hold; r.flush = flush;
    r.e_ready = e_ready; r.e_vo = e_vo; r.e_do = e_do; r.e_occ = e_occ;
    return r;
  endfunction

  task automatic drive0(input logic vi, input logic [3:0] di, input logic hold, input logic [2:0] fl);
    if0.valid_in = vi; if0.data_in = di; if0.hold = hold; if0.flush = fl;
  endtask

  task automatic drive1(input logic vi, input logic [3:0] di, input logic hold, input logic [2:0] fl);
    if1.valid_in = vi; if1.data_in = di; if1.hold = hold; if1.flush = fl;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic vo, input logic [3:0] dout, input logic [1:0] occ);
    chk({tag, "_vo"}, 32'(if1.valid_out), 32'(vo));
    chk({tag, "_do"}, 32'(if1.data_out), 32'(dout));
    chk({tag, "_occ"}, 32'(if1.occupancy), 32'(occ));
  endtask

  // Scoreboard step for u0: record accepts, retire on consumer take.
  task automatic sb_step(input logic vi, input logic [3:0] di, input logic hold);
    drive0(vi, di, hold, 3'b000);
    #1;
    if (vi && if0.ready_in) sb.push_back(di);
    if (if0.valid_out && !hold) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk("sb_data", 32'(if0.data_out), 32'(sb.pop_front()));
      end
    end
    edge_sample();
  endtask

  initial begin
    drive0(1'b0, 4'h0, 1'b0, 3'b000);
    drive1(1'b0, 4'h0, 1'b0, 3'b000);

    // Reset state, checked while reset is still asserted and no edge matters.
    #12;
    chk("rst_vo0", 32'(if0.valid_out), 32'd0);
    chk("rst_do0", 32'(if0.data_out), 32'(rval));
    chk("rst_occ0", 32'(if0.occupancy), 32'd0);
    chk("rst_vo1", 32'(if1.valid_out), 32'd0);
    chk("rst_occ1", 32'(if1.occupancy), 32'd0);
    rst = 1'b0;
    edge_sample();

    // Lockstep vectors: streaming, stall with bubble, flushes, squash while held.
    tbl.push_back(mk(1, 4'h7, 0, 3'b000, 1, 0, rval, 1));
    tbl.push_back(mk(1, 4'h3, 0, 3'b000, 1, 0, rval, 2));
    tbl.push_back(mk(0, 4'h0, 0, 3'b000, 1, 1, 4'h7, 2));
    tbl.push_back(mk(0, 4'h0, 0, 3'b000, 1, 1, 4'h3, 1));
    tbl.push_back(mk(0, 4'h0, 0, 3'b000, 1, 0, 4'h3, 0));
    tbl.push_back(mk(1, 4'h7, 0, 3'b000, 1, 0, 4'h3, 1));
    tbl.push_back(mk(0, 4'h0, 0, 3'b000, 1, 0, 4'h3, 1));
    tbl.push_back(mk(1, 4'h3, 0, 3'b000, 1, 1, 4'h7, 2));
    tbl.push_back(mk(0, 4'h0, 1, 3'b000, 0, 1, 4'h7, 2));
    tbl.push_back(mk(0, 4'h0, 1, 3'b000, 0, 1, 4'h7, 2));
    tbl.push_back(mk(0, 4'h0, 0, 3'b000, 1, 0, 4'h7, 1));
    tbl.push_back(mk(0, 4'h0, 0, 3'b000, 1, 1, 4'h3, 1));
    tbl.push_back(mk(0, 4'h0, 0, 3'b000, 1, 0, 4'h3, 0));
    tbl.push_back(mk(1, 4'h9, 0, 3'b000, 1, 0, 4'h3, 1));
    tbl.push_back(mk(0, 4'h0, 0, 3'b010, 1, 0, 4'h3, 0));
    tbl.push_back(mk(0, 4'h0, 0, 3'b000, 1, 0, 4'h3, 0));
    tbl.push_back(mk(1, 4'h5, 0, 3'b001, 1, 0, 4'h3, 0));
    tbl.push_back(mk(0, 4'h0, 0, 3'b000, 1, 0, 4'h3, 0));
    tbl.push_back(mk(1, 4'h6, 0, 3'b000, 1, 0, 4'h3, 1));
    tbl.push_back(mk(0, 4'h0, 0, 3'b000, 1, 0, 4'h3, 1));
    tbl.push_back(mk(0, 4'h0, 0, 3'b000, 1, 1, 4'h6, 1));
    tbl.push_back(mk(0, 4'h0, 1, 3'b100, 0, 0, 4'h6, 0));
    tbl.push_back(mk(0, 4'h0, 0, 3'b000, 1, 0, 4'h6, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive0(tbl[i].vi, tbl[i].di, tbl[i].hold, tbl[i].flush);
      #1;
      chk($sformatf("t%0d_ready", i), 32'(if0.ready_in), 32'(tbl[i].e_ready));
      edge_sample();
      chk($sformatf("t%0d_vo", i), 32'(if0.valid_out), 32'(tbl[i].e_vo));
      chk($sformatf("t%0d_do", i), 32'(if0.data_out), 32'(tbl[i].e_do));
      chk($sformatf("t%0d_occ", i), 32'(if0.occupancy), 32'(tbl[i].e_occ));
    end
    drive0(1'b0, 4'h0, 1'b0, 3'b000);

    // Collapse mode: build {out:7, mid:bubble, in:3}, then squeeze while held.
    drive1(1, 4'h7, 0, 3'b000); edge_sample();
    drive1(0, 4'h0, 0, 3'b000); edge_sample();
    drive1(1, 4'h3, 0, 3'b000); edge_sample();
    chk1("c_fill", 1, 4'h7, 2);
    drive1(1, 4'h5, 1, 3'b000);
    #1;
    chk("c_ready_pre", 32'(if1.ready_in), 32'd1);
    edge_sample();
    chk1("c_squeeze", 1, 4'h7, 3);
    chk("c_ready_full", 32'(if1.ready_in), 32'd0);
    drive1(1, 4'h8, 1, 3'b000); edge_sample();
    chk1("c_frozen", 1, 4'h7, 3);
    drive1(0, 4'h0, 0, 3'b000);
    #1;
    chk("c_ready_rel", 32'(if1.ready_in), 32'd1);
    edge_sample();
    chk1("c_drain1", 1, 4'h3, 2);
    edge_sample();
    chk1("c_drain2", 1, 4'h5, 1);
    edge_sample();
    chk1("c_drain3", 0, 4'h5, 0);

    // Continuous stream through u0: one output per edge, occupancy pinned at 3.
    for (int k = 0; k < 20; k++) begin
      sb_step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
      if (k >= 2) chk("stream_occ", 32'(if0.occupancy), 32'd3);
    end
    for (int k = 0; k < 4; k++) sb_step(1'b0, 4'h0, 1'b0);

    // Random valid and hold against the scoreboard.
    for (int k = 0; k < 40; k++) begin
      sb_step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
    end
    for (int k = 0; k < 6; k++) sb_step(1'b0, 4'h0, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("sb_occ_empty", 32'(if0.occupancy), 32'd0);

    // Async reset in the middle of a cycle with a full pipe.
    drive0(1, 4'h1, 0, 3'b000); edge_sample();
    drive0(1, 4'h2, 0, 3'b000); edge_sample();
    drive0(1, 4'h3, 0, 3'b000); edge_sample();
    drive0(0, 4'h0, 0, 3'b000);
    chk("ar_occ_full", 32'(if0.occupancy), 32'd3);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_vo", 32'(if0.valid_out), 32'd0);
    chk("ar_do", 32'(if0.data_out), 32'(rval));
    chk("ar_occ", 32'(if0.occupancy), 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive0(1, 4'hC, 0, 3'b000);
    edge_sample();
    drive0(0, 4'h0, 0, 3'b000);
    chk("lat_e1", 32'(if0.valid_out), 32'd0);
    edge_sample();
    chk("lat_e2", 32'(if0.valid_out), 32'd0);
    edge_sample();
    chk("lat_e3_vo", 32'(if0.valid_out), 32'd1);
    chk("lat_e3_do", 32'(if0.data_out), 32'hC);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dffe_pipe.md
Name: dffe_pipe

Overview:
- Parametrised elastic pipeline register: `depth` stages of `data_width`-bit data, each stage with a valid bit.
- Supports a downstream stall (`hold`), per-stage flush and an optional bubble-collapse mode.
- Successor to the single-stage hold register. Used between CPU pipeline stages (IF/ID/EX/MEM/WB) and for multi-cycle delay lines with stall/squash.

Parameters:
- data_width, 32, width of each data stage
- depth, 1, number of stages (>=1); stage 0 is input side, stage depth-1 drives outputs
- collapse, 0, 0 = lockstep stall (all stages freeze on hold); 1 = bubbles may be squeezed out while held
- reset_value, 0, value loaded into every data stage on reset

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- hold  input  1  downstream cannot accept stage depth-1 this cycle
- flush  input  depth  flush[i] invalidates the value entering stage i at this edge
- valid_in  input  1  data_in carries a valid item
- data_in  input  data_width  input data
- ready_in  output  1  input accepted this edge when valid_in & ready_in
- valid_out  output  1  valid bit of stage depth-1
- data_out  output  data_width  data of stage depth-1
- occupancy  output  clog2(depth+1)  registered count of valid stages

Behaviour:
- Reset (async, immediate, no clock needed): all v[i]=0, all d[i]=reset_value, occupancy=0. Therefore valid_out=0 and data_out=reset_value. Reset mid-stream discards all contents.
- Advance enables (combinational):
  - collapse=0: adv[i] = ~hold for all i.
  - collapse=1: adv[depth-1] = ~hold | ~v[depth-1]; adv[i] = adv[i+1] | ~v[i].
- ready_in = adv[0]. With collapse=0 it is independent of valid bits.
- On each rising edge, for every stage with adv[i]=1, taking src = stage i-1 (or the input for i=0):
  - v[i] <= src_valid & ~flush[i].
  - d[i] <= src_data only when src_valid=1; otherwise d[i] keeps its old value (no toggling on bubbles).
- Stage with adv[i]=0: holds v[i] and d[i], except flush[i]=1 still clears v[i] (squash while stalled).
- Latency with hold=0: exactly depth cycles from accept to valid_out.
- data_out is always d[depth-1], even when valid_out=0.
- The consumer takes an item on an edge where valid_out & ~hold.
- occupancy <= popcount of next-state v; it must equal popcount(v) at all times.
- Simultaneous accept and emit: occupancy unchanged.
- Input accepted while flush[0]=1: the item is dropped; ready_in is still reported high.
- Full pipeline with collapse=1 and hold=1: ready_in=0 and no state changes, except flushes.
- collapse=0: a bubble entering with hold=0 propagates as v=0.
- depth=1, collapse=0 reduces to the single-stage hold register plus a valid bit.

Decomposition:
- define.v gets the shared macros: the CLOG2 width helper and global DATA_WIDTH default (32).
- One natural sub-module: pipe_stage, containing one valid+data register with load, flush and async reset.
- dffe_pipe instantiates depth copies of pipe_stage via generate and adds the advance chain and occupancy register.

Test Plan:
1. depth=3, data_width=4, collapse=0, hold=0; valid_in with data_in=7 then 3 on consecutive edges -> valid_out=1, data_out=7 after 3rd edge, data_out=3 after 4th; occupancy 1,2,2,1 after successive edges.
2. collapse=0, stages hold {out:7, mid:bubble, in:3}, hold=1 for 2 cycles -> ready_in=0, data_out=7, valid_out=1 unchanged. On release, 7 is consumed and the bubble reaches the output next edge.
3. collapse=1, same contents, hold=1, valid_in with data_in=5 -> edge 1: mid=3, in=5, ready_in=1 before the edge. After the edge ready_in=0, occupancy=3, data_out still 7.
4. Flush: depth=3, data_in=9 accepted and next edge flush=3'b010 -> 9 never appears with valid_out=1; occupancy returns to 0.
5. Full pipeline, hold=0, continuous valid_in 1,2,3,4 -> one output per edge, occupancy steady at 3, ready_in=1 throughout.
6. Async reset asserted between clock edges while occupancy=3 -> valid_out=0, data_out=reset_value, occupancy=0, all before the next edge. After deassertion, the first accepted item appears after exactly depth edges.
